vdp18_access_sched: RTL and testbench
=====================================

# vdp18_access_sched

VRAM access slot scheduler for the VDP18 core. On every access-slot strobe it decides which VRAM access the memory controller performs next (pattern fetch, sprite test, sprite attribute/pattern fetch, CPU, or none) from the current raster position and operating mode. It also arbitrates pending CPU requests into free slots. It sits between the horizontal/vertical counter block and the VRAM memory controller, and emits `vdp18_pkg::access_t`.

## Interface
- `SPR_SLOTS`, default 6: accesses per sprite in the sprite fetch region. Fixed; any other value is unsupported.
- `clk_i` in 1: core clock.
- `reset_i` in 1: reset, synchronous, active-high.
- `clk_en_acc_i` in 1: access-slot strobe, one pulse per 2 pixels, coincident with even `num_pix_i`.
- `opmode_i` in 2: `opmode_t` (GRAPH1/GRAPH2/MULTIC/TEXTM).
- `blank_i` in 1: display disabled.
- `vert_active_i` in 1: raster lines 0..191.
- `num_pix_i` in 9: signed pixel counter, -102..255.
- `spr_cnt_i` in 3: sprites found by the sprite test for this line, 0..4.
- `cpu_req_i` in 1: one-cycle CPU access request pulse.
- `access_type_o` out 4: `access_t` for the current slot.
- `spr_num_o` out 5: sprite number. 0..31 for AC_STST; 0..3 for the SAT*/SPT* accesses.
- `cpu_ack_o` out 1: one-cycle grant pulse.

## Operation
- Pending flag `pend`: set by `cpu_req_i`, cleared on grant. A request that arrives while `pend`=1 is absorbed. Free slot = AC_CPU if `pend`, otherwise AC_NONE.
- Priority per slot: blank/vertical, then mode region, then free.
- `blank_i`=1 or `vert_active_i`=0: every slot is free.
- Graphics modes (GRAPH1, GRAPH2, MULTIC):
  - Sprite region, `num_pix_i` -86..-40: 24 slots.
  - Internal slot counter `sub` 0..5 and sprite counter `sidx` 0..3, both reset when `num_pix_i` = -86.
  - `sub` sequence: SATY, SATX, SATN, SATC, SPTH, SPTL; `spr_num_o`=`sidx`.
  - Pattern region, `num_pix_i` -8..247: phase = `num_pix_i[2:1]`.
    - Phase 0: PNT. Phase 1: PCT. Phase 2: PGT. Phase 3: STST.
    - In MULTIC, phase 1 is free.
    - STST counter: reset to 0 at `num_pix_i` = -8, incremented after each STST, wraps 31→0. `spr_num_o` = counter.
  - All other positions: free.
- TEXTM:
  - Region `num_pix_i` -6..233: mod-3 counter reset at -6; sequence PNT, PGT, free.
  - No sprite or STST accesses in TEXTM.
  - Everywhere else: free.
- `spr_num_o` holds its last value on accesses that do not use it.

## Timing
- Reset: `access_type_o`=AC_NONE, `spr_num_o`=0, `cpu_ack_o`=0, `pend`=0, all counters 0.
- Outputs are registered and update on the clock edge after `clk_en_acc_i`. They hold until the next strobe.
- `cpu_ack_o` pulses for exactly one cycle, in the same cycle `access_type_o` becomes AC_CPU.
- A slot decision uses the registered `pend`. A `cpu_req_i` in the strobe cycle is not seen by that slot.
- Grant and a new request in the same cycle: `pend` stays 1.
- Worst-case CPU latency in graphics active lines: from pixel -8 to pixel 248, i.e. 128 slots plus 1 cycle.
- `opmode_i`, `blank_i`, and `spr_cnt_i` are sampled at each strobe. A change mid-line takes effect at the next slot, and counters are not re-synchronised until their reset position.
- `reset_i` mid-operation: returns to reset values on the next edge. A pending request is dropped.

## Configuration
- `VDP18_SPRITE_CNT_EN`:
  - Defined: sprite-region slots with `sidx` >= `spr_cnt_i` become free slots.
  - Undefined: all 24 sprite-region slots are always issued and `spr_cnt_i` is ignored.

## Test plan
- Reset with `cpu_req_i` pulsed, then release: AC_NONE, `spr_num_o`=0, no ack until the first free slot after the release.
- GRAPH2, `vert_active_i`=1, `num_pix_i` -8,-6,-4,-2: PNT, PCT, PGT, STST with `spr_num_o`=0. At 246: STST with `spr_num_o`=31.
- GRAPH1, `num_pix_i` -86..-40: SATY..SPTL repeated four times, `spr_num_o` 0,0,0,0,0,0,1,…,3. With the macro defined and `spr_cnt_i`=2, slots from -62 on are free.
- TEXTM, request pulsed at `num_pix_i`=-6: PNT, then PGT, then AC_CPU at -2 with `cpu_ack_o` pulsed once and `pend` cleared.
- `blank_i`=1, two requests 3 cycles apart before one strobe: a single AC_CPU and a single ack. The next strobe gives AC_NONE.
- Request in the same cycle as a grant: two consecutive free slots both give AC_CPU, with two acks.

Source files
------------

// File: rtl/vdp18_access_sched.sv
// vdp18_access_sched: VRAM access slot scheduler for the VDP18 core.
// On each access-slot strobe it picks the next VRAM access (pattern fetch,
// sprite test, sprite attribute/pattern fetch, CPU or none) from the raster
// position and the operating mode, and fits pending CPU requests into free slots.
// Optional feature macro: VDP18_SPRITE_CNT_EN (when defined, sprite-region
// slots for sprites that were not found by the sprite test become free slots).

package vdp18_pkg;

  typedef enum logic [1:0] {
    OPMODE_GRAPH1 = 2'd0,
    OPMODE_GRAPH2 = 2'd1,
    OPMODE_MULTIC = 2'd2,
    OPMODE_TEXTM  = 2'd3
  } opmode_t;

  typedef enum logic [3:0] {
    AC_NONE = 4'd0,
    AC_PNT  = 4'd1,
    AC_PCT  = 4'd2,
    AC_PGT  = 4'd3,
    AC_STST = 4'd4,
    AC_SATY = 4'd5,
    AC_SATX = 4'd6,
    AC_SATN = 4'd7,
    AC_SATC = 4'd8,
    AC_SPTH = 4'd9,
    AC_SPTL = 4'd10,
    AC_CPU  = 4'd11
  } access_t;

endpackage

module vdp18_access_sched #(
  parameter int SPR_SLOTS = 6
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clk_en_acc_i,
  input  vdp18_pkg::opmode_t  opmode_i,
  input  logic                blank_i,
  input  logic                vert_active_i,
  input  logic [8:0]          num_pix_i,
  input  logic [2:0]          spr_cnt_i,
  input  logic                cpu_req_i,
  output vdp18_pkg::access_t  access_type_o,
  output logic [4:0]          spr_num_o,
  output logic                cpu_ack_o
);

  import vdp18_pkg::*;

  // Registered state
  access_t     r_access;
  logic [4:0]  r_spr_num;
  logic        r_ack;
  logic        r_pend;
  logic [2:0]  r_sub;
  logic [1:0]  r_sidx;
  logic [4:0]  r_stst;
  logic [1:0]  r_tcnt;

  // Combinational helpers
  logic signed [8:0] w_pix;
  logic        w_in_spr;
  logic        w_in_pat;
  logic        w_in_txt;
  logic [2:0]  w_sub_eff;
  logic [1:0]  w_sidx_eff;
  logic [1:0]  w_tcnt_eff;
  logic        w_spr_skip;
  access_t     w_slot;
  access_t     w_final;
  logic        w_free;
  logic [4:0]  w_spr_num;
  logic        w_stst_issue;
  logic        w_grant;

  assign w_pix    = num_pix_i;
  assign w_in_spr = (w_pix >= -9'sd86) && (w_pix <= -9'sd40);
  assign w_in_pat = (w_pix >= -9'sd8)  && (w_pix <= 9'sd247);
  assign w_in_txt = (w_pix >= -9'sd6)  && (w_pix <= 9'sd233);

  // Counters restart at the first slot of their region, so that slot already
  // uses the restarted value rather than whatever was left from the last line.
  assign w_sub_eff  = (w_pix == -9'sd86) ? 3'd0 : r_sub;
  assign w_sidx_eff = (w_pix == -9'sd86) ? 2'd0 : r_sidx;
  assign w_tcnt_eff = (w_pix == -9'sd6)  ? 2'd0 : r_tcnt;

`ifdef VDP18_SPRITE_CNT_EN
  assign w_spr_skip = ({1'b0, w_sidx_eff} >= spr_cnt_i);
`else
  logic w_unused_spr_cnt;
  assign w_unused_spr_cnt = ^spr_cnt_i;
  assign w_spr_skip = 1'b0;
`endif

  // Decide the mode-driven access for this slot, or mark the slot as free.
  always_comb begin
    w_slot       = AC_NONE;
    w_free       = 1'b1;
    w_spr_num    = r_spr_num;
    w_stst_issue = 1'b0;
    if (blank_i || !vert_active_i) begin
      w_free = 1'b1;
    end else if (opmode_i != OPMODE_TEXTM) begin
      if (w_in_spr && !w_spr_skip) begin
        w_free    = 1'b0;
        w_spr_num = {3'b000, w_sidx_eff};
        case (w_sub_eff)
          3'd0:    w_slot = AC_SATY;
          3'd1:    w_slot = AC_SATX;
          3'd2:    w_slot = AC_SATN;
          3'd3:    w_slot = AC_SATC;
          3'd4:    w_slot = AC_SPTH;
          3'd5:    w_slot = AC_SPTL;
          default: begin
            w_free    = 1'b1;
            w_spr_num = r_spr_num;
          end
        endcase
      end else if (w_in_pat) begin
        case (w_pix[2:1])
          2'd0: begin
            w_free = 1'b0;
            w_slot = AC_PNT;
          end
          2'd1: begin
            // Multicolor mode has no colour table fetch; the slot goes to the CPU.
            if (opmode_i == OPMODE_MULTIC) begin
              w_free = 1'b1;
            end else begin
              w_free = 1'b0;
              w_slot = AC_PCT;
            end
          end
          2'd2: begin
            w_free = 1'b0;
            w_slot = AC_PGT;
          end
          2'd3: begin
            w_free       = 1'b0;
            w_slot       = AC_STST;
            w_spr_num    = r_stst;
            w_stst_issue = 1'b1;
          end
          default: w_free = 1'b1;
        endcase
      end else begin
        w_free = 1'b1;
      end
    end else begin
      if (w_in_txt) begin
        case (w_tcnt_eff)
          2'd0: begin
            w_free = 1'b0;
            w_slot = AC_PNT;
          end
          2'd1: begin
            w_free = 1'b0;
            w_slot = AC_PGT;
          end
          default: w_free = 1'b1;
        endcase
      end else begin
        w_free = 1'b1;
      end
    end
  end

  // Free slots go to the CPU only when a request was already pending before the strobe.
  assign w_final = w_free ? (r_pend ? AC_CPU : AC_NONE) : w_slot;
  assign w_grant = clk_en_acc_i & w_free & r_pend;

  // Slot outputs, CPU request bookkeeping and position counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_access  <= AC_NONE;
      r_spr_num <= 5'd0;
      r_ack     <= 1'b0;
      r_pend    <= 1'b0;
      r_sub     <= 3'd0;
      r_sidx    <= 2'd0;
      r_stst    <= 5'd0;
      r_tcnt    <= 2'd0;
    end else begin
      r_pend <= (r_pend & ~w_grant) | cpu_req_i;
      r_ack  <= w_grant;
      if (clk_en_acc_i) begin
        r_access  <= w_final;
        r_spr_num <= w_spr_num;
        if (w_in_spr) begin
          if (w_sub_eff == 3'(SPR_SLOTS - 1)) begin
            r_sub  <= 3'd0;
            r_sidx <= w_sidx_eff + 2'd1;
          end else begin
            r_sub  <= w_sub_eff + 3'd1;
            r_sidx <= w_sidx_eff;
          end
        end
        if (w_pix == -9'sd8) begin
          r_stst <= 5'd0;
        end else if (w_stst_issue) begin
          r_stst <= r_stst + 5'd1;
        end
        if (w_in_txt) begin
          r_tcnt <= (w_tcnt_eff == 2'd2) ? 2'd0 : (w_tcnt_eff + 2'd1);
        end
      end
    end
  end

  assign access_type_o = r_access;
  assign spr_num_o     = r_spr_num;
  assign cpu_ack_o     = r_ack;

endmodule

// File: tb/tb_vdp18_access_sched.sv
// Self-checking bench for vdp18_access_sched: expected slot results are queued
// when a strobe is driven and compared once the registered outputs update.
module tb_vdp18_access_sched;

  import vdp18_pkg::*;

  typedef struct {
    access_t    acc;
    logic [4:0] num;
    logic       ack;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  opmode_t     opmode;
  logic        blank;
  logic        vert_active;
  logic [8:0]  num_pix;
  logic [2:0]  spr_cnt;
  logic        cpu_req;
  access_t     acc_o;
  logic [4:0]  num_o;
  logic        ack_o;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [4:0]  last_num = 5'd0;
  access_t     spr_seq[6] = '{AC_SATY, AC_SATX, AC_SATN, AC_SATC, AC_SPTH, AC_SPTL};

  vdp18_access_sched #(.SPR_SLOTS(6)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .clk_en_acc_i  (clk_en),
    .opmode_i      (opmode),
    .blank_i       (blank),
    .vert_active_i (vert_active),
    .num_pix_i     (num_pix),
    .spr_cnt_i     (spr_cnt),
    .cpu_req_i     (cpu_req),
    .access_type_o (acc_o),
    .spr_num_o     (num_o),
    .cpu_ack_o     (ack_o)
  );

  always #5 clk = ~clk;

  // Drive one strobe (optionally with a request in the same cycle) and queue
  // the expected outcome; returns on the falling edge after the update edge.
  task automatic drive_slot(input int pix, input logic req, input access_t e_acc,
                            input logic [4:0] e_num, input logic e_ack);
    exp_t e;
    @(negedge clk);
    clk_en  = 1'b1;
    num_pix = 9'(pix);
    cpu_req = req;
    e.acc = e_acc;
    e.num = e_num;
    e.ack = e_ack;
    q.push_back(e);
    @(negedge clk);
    clk_en  = 1'b0;
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; cpu_req = 1'b1; clk_en = 1'b0; opmode = OPMODE_GRAPH1;
    blank = 1'b1; vert_active = 1'b0; num_pix = 9'd0; spr_cnt = 3'd0;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if (acc_o !== AC_NONE) begin n_err++; $display("FAIL reset_acc: got %0d, expected %0d", acc_o, AC_NONE); end
    n_vec++;
    if (num_o !== 5'd0) begin n_err++; $display("FAIL reset_num: got %0d, expected 0", num_o); end
    n_vec++;
    if (ack_o !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %0b, expected 0", ack_o); end
    // The request seen during reset must have been dropped.
    drive_slot(0, 1'b0, AC_NONE, 5'd0, 1'b0);
    e = q.pop_front();
    n_vec++;
    if (acc_o !== e.acc || num_o !== e.num || ack_o !== e.ack)
      begin n_err++; $display("FAIL reset_first_slot: got acc=%0d num=%0d ack=%0b, expected acc=%0d num=%0d ack=%0b", acc_o, num_o, ack_o, e.acc, e.num, e.ack); end
  endtask

  task automatic test_graph2_line();
    exp_t    e;
    access_t ea;
    opmode = OPMODE_GRAPH2; blank = 1'b0; vert_active = 1'b1;
    for (int pix = -8; pix <= 248; pix += 2) begin
      ea = AC_NONE;
      if (pix <= 247) begin
        case (((pix + 8) / 2) % 4)
          0: ea = AC_PNT;
          1: ea = AC_PCT;
          2: ea = AC_PGT;
          default: begin ea = AC_STST; last_num = 5'((pix + 8) / 8); end
        endcase
      end
      drive_slot(pix, 1'b0, ea, last_num, 1'b0);
      e = q.pop_front();
      n_vec++;
      if (acc_o !== e.acc || num_o !== e.num || ack_o !== e.ack)
        begin n_err++; $display("FAIL graph2 pix=%0d: got acc=%0d num=%0d ack=%0b, expected acc=%0d num=%0d ack=%0b", pix, acc_o, num_o, ack_o, e.acc, e.num, e.ack); end
    end
  endtask

  task automatic test_multic();
    exp_t    e;
    access_t tab[4] = '{AC_PNT, AC_NONE, AC_PGT, AC_STST};
    opmode = OPMODE_MULTIC; blank = 1'b0; vert_active = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) last_num = 5'd0;
      drive_slot(-8 + 2 * k, 1'b0, tab[k], last_num, 1'b0);
      e = q.pop_front();
      n_vec++;
      if (acc_o !== e.acc || num_o !== e.num || ack_o !== e.ack)
        begin n_err++; $display("FAIL multic k=%0d: got acc=%0d num=%0d ack=%0b, expected acc=%0d num=%0d ack=%0b", k, acc_o, num_o, ack_o, e.acc, e.num, e.ack); end
    end
  endtask

  task automatic test_sprite();
    exp_t    e;
    access_t ea;
    opmode = OPMODE_GRAPH1; blank = 1'b0; vert_active = 1'b1; spr_cnt = 3'd2;
    for (int k = 0; k <= 24; k++) begin
      ea = AC_NONE;
      if (k < 24) begin
`ifdef VDP18_SPRITE_CNT_EN
        if (k / 6 < 2) begin ea = spr_seq[k % 6]; last_num = 5'(k / 6); end
`else
        ea = spr_seq[k % 6];
        last_num = 5'(k / 6);
`endif
      end
      drive_slot(-86 + 2 * k, 1'b0, ea, last_num, 1'b0);
      e = q.pop_front();
      n_vec++;
      if (acc_o !== e.acc || num_o !== e.num || ack_o !== e.ack)
        begin n_err++; $display("FAIL sprite k=%0d: got acc=%0d num=%0d ack=%0b, expected acc=%0d num=%0d ack=%0b", k, acc_o, num_o, ack_o, e.acc, e.num, e.ack); end
    end
    spr_cnt = 3'd0;
  endtask

  task automatic test_textm_cpu();
    exp_t    e;
    access_t tab[6] = '{AC_PNT, AC_PGT, AC_CPU, AC_PNT, AC_PGT, AC_NONE};
    opmode = OPMODE_TEXTM; blank = 1'b0; vert_active = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive_slot(-6 + 2 * k, (k == 0), tab[k], last_num, (k == 2));
      e = q.pop_front();
      n_vec++;
      if (acc_o !== e.acc || num_o !== e.num || ack_o !== e.ack)
        begin n_err++; $display("FAIL textm k=%0d: got acc=%0d num=%0d ack=%0b, expected acc=%0d num=%0d ack=%0b", k, acc_o, num_o, ack_o, e.acc, e.num, e.ack); end
      if (k == 2) begin
        @(negedge clk);
        n_vec++;
        if (ack_o !== 1'b0 || acc_o !== AC_CPU)
          begin n_err++; $display("FAIL textm_ack_pulse: got ack=%0b acc=%0d, expected ack=0 acc=%0d", ack_o, acc_o, AC_CPU); end
      end
    end
  endtask

  task automatic test_blank_absorb();
    exp_t e;
    opmode = OPMODE_GRAPH2; blank = 1'b1; vert_active = 1'b1;
    @(negedge clk); cpu_req = 1'b1;
    @(negedge clk); cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk); cpu_req = 1'b1;
    @(negedge clk); cpu_req = 1'b0;
    drive_slot(0, 1'b0, AC_CPU, last_num, 1'b1);
    e = q.pop_front();
    n_vec++;
    if (acc_o !== e.acc || num_o !== e.num || ack_o !== e.ack)
      begin n_err++; $display("FAIL blank_grant: got acc=%0d num=%0d ack=%0b, expected acc=%0d num=%0d ack=%0b", acc_o, num_o, ack_o, e.acc, e.num, e.ack); end
    @(negedge clk);
    n_vec++;
    if (ack_o !== 1'b0) begin n_err++; $display("FAIL blank_ack_pulse: got %0b, expected 0", ack_o); end
    drive_slot(2, 1'b0, AC_NONE, last_num, 1'b0);
    e = q.pop_front();
    n_vec++;
    if (acc_o !== e.acc || num_o !== e.num || ack_o !== e.ack)
      begin n_err++; $display("FAIL blank_after: got acc=%0d num=%0d ack=%0b, expected acc=%0d num=%0d ack=%0b", acc_o, num_o, ack_o, e.acc, e.num, e.ack); end
  endtask

  task automatic test_back_to_back();
    exp_t    e;
    access_t tab[3] = '{AC_CPU, AC_CPU, AC_NONE};
    opmode = OPMODE_GRAPH1; blank = 1'b0; vert_active = 1'b0;
    @(negedge clk); cpu_req = 1'b1;
    @(negedge clk); cpu_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_slot(2 * k, (k == 0), tab[k], last_num, (k < 2));
      e = q.pop_front();
      n_vec++;
      if (acc_o !== e.acc || num_o !== e.num || ack_o !== e.ack)
        begin n_err++; $display("FAIL back_to_back k=%0d: got acc=%0d num=%0d ack=%0b, expected acc=%0d num=%0d ack=%0b", k, acc_o, num_o, ack_o, e.acc, e.num, e.ack); end
    end
  endtask

  initial begin
    test_reset();
    test_graph2_line();
    test_multic();
    test_sprite();
    test_textm_cpu();
    test_blank_absorb();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
